// File: rtl/prim_lfsr_arb_pkg.sv
// rtl/prim_lfsr_arb_pkg.sv - shared types and helpers for the LFSR arbiter
package prim_lfsr_arb_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SREQ = 2'd1,
    LOAD = 2'd2
  } arb_state_e;

  // Bits needed to index n items (never less than one bit).
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin pointer width for a given requester count.
  function automatic int ptr_w(int num_req);
    return cnt_w(num_req);
  endfunction

  // Grant counter width: must hold values 0..reseed_cnt inclusive.
  function automatic int gcnt_w(int reseed_cnt);
    return cnt_w(reseed_cnt + 1);
  endfunction

  // Right-shifting Galois feedback masks giving maximal-length sequences;
  // zero marks an unsupported width.
  function automatic logic [63:0] gal_xor_coeff(int width);
    case (width)
      4:       return 64'h9;
      8:       return 64'hB8;
      16:      return 64'hD008;
      32:      return 64'h8000_0057;
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/prim_lfsr_arb_if.sv
// rtl/prim_lfsr_arb_if.sv - request/grant, data and reseed signals of the LFSR arbiter
interface prim_lfsr_arb_if #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned LfsrDw = 32,
  parameter int unsigned OutDw  = 8
);
  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] gnt_o;
  logic [OutDw-1:0]  data_o;
  logic              reseed_i;
  logic              seed_req_o;
  logic              seed_ack_i;
  logic [LfsrDw-1:0] seed_i;
  logic              lockup_o;

  modport slave (
    input  req_i, reseed_i, seed_ack_i, seed_i,
    output gnt_o, data_o, seed_req_o, lockup_o
  );

  modport master (
    output req_i, reseed_i, seed_ack_i, seed_i,
    input  gnt_o, data_o, seed_req_o, lockup_o
  );
endinterface

// File: rtl/prim_lfsr.sv
// rtl/prim_lfsr.sv - Galois XOR LFSR with seed load and entropy injection
module prim_lfsr
  import prim_lfsr_arb_pkg::*;
#(
  parameter string             LfsrType    = "GAL_XOR",
  parameter int unsigned       LfsrDw      = 32,
  parameter int unsigned       EntropyDw   = 8,
  parameter logic [LfsrDw-1:0] DefaultSeed = LfsrDw'(1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 seed_en_i,
  input  logic [LfsrDw-1:0]    seed_i,
  input  logic                 lfsr_en_i,
  input  logic [EntropyDw-1:0] entropy_i,
  output logic [LfsrDw-1:0]    state_o
);

  localparam logic [LfsrDw-1:0] Coeff = LfsrDw'(gal_xor_coeff(int'(LfsrDw)));

  if (LfsrType != "GAL_XOR") begin : g_type_chk
    $error("prim_lfsr: only GAL_XOR is implemented");
  end
  if (Coeff == '0) begin : g_width_chk
    $error("prim_lfsr: no feedback mask for this LfsrDw");
  end
  if (EntropyDw > LfsrDw) begin : g_ent_chk
    $error("prim_lfsr: EntropyDw must not exceed LfsrDw");
  end

  logic [LfsrDw-1:0] lfsr_q;
  logic [LfsrDw-1:0] lfsr_next;

  // One Galois step: shift right, fold the feedback mask in when bit 0 is set.
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[LfsrDw-1:1]} ^ ({LfsrDw{lfsr_q[0]}} & Coeff)
              ^ LfsrDw'(entropy_i);
  end

  // State register: seed load has priority over stepping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= DefaultSeed;
    end else if (seed_en_i) begin
      lfsr_q <= seed_i;
    end else if (lfsr_en_i) begin
      lfsr_q <= lfsr_next;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/prim_lfsr_arb.sv
// rtl/prim_lfsr_arb.sv - round-robin sharing of one LFSR with reseed and lockup control
module prim_lfsr_arb
  import prim_lfsr_arb_pkg::*;
#(
  parameter int unsigned       NumReq    = 4,
  parameter int unsigned       LfsrDw    = 32,
  parameter int unsigned       OutDw     = 8,
  parameter logic [LfsrDw-1:0] Seed      = LfsrDw'(1),
  parameter int unsigned       ReseedCnt = 256
) (
  input logic            clk_i,
  input logic            rst_i,
  prim_lfsr_arb_if.slave bus
);

  localparam int PtrW  = ptr_w(int'(NumReq));
  localparam int GcntW = gcnt_w(int'(ReseedCnt));
  localparam int IdxW  = PtrW + 1;
  localparam int ReqW2 = 2 * int'(NumReq);

  if (Seed == '0) begin : g_seed_chk
    $error("prim_lfsr_arb: Seed must be nonzero");
  end
  if (OutDw > LfsrDw) begin : g_dw_chk
    $error("prim_lfsr_arb: OutDw must not exceed LfsrDw");
  end
  if (NumReq < 2) begin : g_req_chk
    $error("prim_lfsr_arb: NumReq must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d, winner;
  logic [GcntW-1:0]  gcnt_q, gcnt_d;
  logic [LfsrDw-1:0] seed_q, seed_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [OutDw-1:0]  data_q, data_d;
  logic              lockup_q, lockup_d;
  logic [LfsrDw-1:0] lfsr_state, lfsr_seed;
  logic              lfsr_en, lfsr_seed_en, lfsr_zero, grant;
  logic [ReqW2-1:0]  req2, mask, masked;
  logic [IdxW-1:0]   win_idx;

  prim_lfsr #(
    .LfsrType   ("GAL_XOR"),
    .LfsrDw     (LfsrDw),
    .EntropyDw  (1),
    .DefaultSeed(Seed)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_ni   (~rst_i),
    .seed_en_i(lfsr_seed_en),
    .seed_i   (lfsr_seed),
    .lfsr_en_i(lfsr_en),
    .entropy_i(1'b0),
    .state_o  (lfsr_state)
  );

  assign lfsr_zero = (lfsr_state == '0);

  // Round-robin pick: duplicate the requests, mask off positions below ptr,
  // and the lowest surviving bit (folded back modulo NumReq) wins.
  always_comb begin
    req2    = {bus.req_i, bus.req_i};
    mask    = ~((ReqW2'(1) << ptr_q) - ReqW2'(1));
    masked  = req2 & mask;
    win_idx = '0;
    for (int i = ReqW2 - 1; i >= 0; i--) begin
      if (masked[i]) win_idx = IdxW'(i);
    end
    winner = (win_idx >= IdxW'(NumReq)) ? PtrW'(win_idx - IdxW'(NumReq))
                                        : PtrW'(win_idx);
  end

  // Next-state, grant issue, LFSR control and reseed sequencing.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gcnt_d       = gcnt_q;
    seed_d       = seed_q;
    gnt_d        = '0;
    data_d       = data_q;
    lockup_d     = lockup_q;
    lfsr_en      = 1'b0;
    lfsr_seed_en = 1'b0;
    lfsr_seed    = seed_q;
    grant        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (lfsr_zero) begin
          // Stuck LFSR: flag it, skip this cycle's grant and restart from Seed.
          lockup_d     = 1'b1;
          lfsr_seed_en = 1'b1;
          lfsr_seed    = Seed;
        end else if (|bus.req_i) begin
          grant   = 1'b1;
          gnt_d   = NumReq'(1) << winner;
          data_d  = lfsr_state[OutDw-1:0];
          lfsr_en = 1'b1;
          ptr_d   = (winner == PtrW'(NumReq - 1)) ? '0 : winner + 1'b1;
          gcnt_d  = gcnt_q + 1'b1;
        end
        if (bus.reseed_i ||
            ((ReseedCnt != 0) && grant && (gcnt_d == GcntW'(ReseedCnt)))) begin
          state_d = SREQ;
        end
      end
      SREQ: begin
        if (bus.seed_ack_i) begin
          seed_d  = (bus.seed_i == '0) ? Seed : bus.seed_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        lfsr_seed_en = 1'b1;
        gcnt_d       = '0;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      ptr_q    <= '0;
      gcnt_q   <= '0;
      seed_q   <= Seed;
      gnt_q    <= '0;
      data_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gcnt_q   <= gcnt_d;
      seed_q   <= seed_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.data_o     = data_q;
  assign bus.seed_req_o = (state_q == SREQ);
  assign bus.lockup_o   = lockup_q;

endmodule

// File: tb/tb_prim_lfsr_arb.sv
// tb/tb_prim_lfsr_arb.sv - self-checking bench for prim_lfsr_arb
module tb_prim_lfsr_arb;

  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'd1;
  localparam logic [31:0] POLY = 32'h8000_0057;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        reseed;
  logic        ack;
  logic [31:0] seed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_lfsr_arb_if #(.NumReq(4), .LfsrDw(32), .OutDw(8)) bus0 ();
  prim_lfsr_arb_if #(.NumReq(4), .LfsrDw(32), .OutDw(8)) bus1 ();

  assign bus0.req_i = req;
  assign bus0.reseed_i = reseed;
  assign bus0.seed_ack_i = ack;
  assign bus0.seed_i = seed;
  assign bus1.req_i = req;
  assign bus1.reseed_i = reseed;
  assign bus1.seed_ack_i = ack;
  assign bus1.seed_i = seed;

  prim_lfsr_arb #(.NumReq(4), .LfsrDw(32), .OutDw(8), .Seed(32'd1), .ReseedCnt(256)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  prim_lfsr_arb #(.NumReq(4), .LfsrDw(32), .OutDw(8), .Seed(32'd1), .ReseedCnt(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  // Reference state per instance; mode 0 = granting, 1 = awaiting seed, 2 = loading.
  int          rc     [2] = '{256, 4};
  logic [31:0] m_lfsr [2];
  logic [31:0] m_seed [2];
  int          m_ptr  [2];
  int          m_gcnt [2];
  int          m_mode [2];
  bit          m_lock [2];
  logic [3:0]  e_gnt  [2];
  logic [7:0]  e_data [2];

  logic [3:0]  seq_gnt  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0]  seq_data [8] = '{8'h01, 8'h57, 8'h7C, 8'h3E, 8'h1F, 8'h58, 8'h2C, 8'h16};
  logic [7:0]  seen     [16];

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic model_step(int k);
    int idx;
    bit granted;
    idx = 0;
    granted = 1'b0;
    e_gnt[k] = '0;
    if (rst) begin
      m_lfsr[k] = SEED; m_seed[k] = SEED; m_ptr[k] = 0; m_gcnt[k] = 0;
      m_mode[k] = 0; m_lock[k] = 1'b0; e_data[k] = '0;
      return;
    end
    case (m_mode[k])
      0: begin
        if (m_lfsr[k] == 0) begin
          m_lock[k] = 1'b1;
          m_lfsr[k] = SEED;
        end else if (req != 0) begin
          for (int off = 0; off < N; off++) begin
            idx = (m_ptr[k] + off) % N;
            if (req[idx]) break;
          end
          e_gnt[k][idx] = 1'b1;
          e_data[k] = m_lfsr[k][7:0];
          m_lfsr[k] = lfsr_step(m_lfsr[k]);
          m_ptr[k] = (idx + 1) % N;
          m_gcnt[k]++;
          granted = 1'b1;
        end
        if (reseed || (rc[k] != 0 && granted && m_gcnt[k] == rc[k])) m_mode[k] = 1;
      end
      1: if (ack) begin
        m_seed[k] = (seed == 0) ? SEED : seed;
        m_mode[k] = 2;
      end
      default: begin
        m_lfsr[k] = m_seed[k];
        m_gcnt[k] = 0;
        m_mode[k] = 0;
      end
    endcase
  endtask

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic compare(int k);
    if (k == 0) begin
      check("gnt", 0, 32'(bus0.gnt_o), 32'(e_gnt[0]));
      check("data", 0, 32'(bus0.data_o), 32'(e_data[0]));
      check("seed_req", 0, 32'(bus0.seed_req_o), 32'(m_mode[0] == 1));
      check("lockup", 0, 32'(bus0.lockup_o), 32'(m_lock[0]));
    end else begin
      check("gnt", 1, 32'(bus1.gnt_o), 32'(e_gnt[1]));
      check("data", 1, 32'(bus1.data_o), 32'(e_data[1]));
      check("seed_req", 1, 32'(bus1.seed_req_o), 32'(m_mode[1] == 1));
      check("lockup", 1, 32'(bus1.lockup_o), 32'(m_lock[1]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    int rep;
    rst = 1'b1; req = '0; reseed = 1'b0; ack = 1'b0; seed = '0;
    cycle();
    cycle();
    check("rst_gnt", 0, 32'(bus0.gnt_o), 32'h0);
    check("rst_data", 0, 32'(bus0.data_o), 32'h0);
    check("rst_seed_req", 0, 32'(bus0.seed_req_o), 32'h0);

    // All four requesting: rotating grants, consecutive LFSR words from Seed.
    rst = 1'b0; req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("seq_gnt", 0, 32'(bus0.gnt_o), 32'(seq_gnt[i]));
      check("seq_data", 0, 32'(bus0.data_o), 32'(seq_data[i]));
      if (i == 4) begin
        check("rc4_seed_req", 1, 32'(bus1.seed_req_o), 32'h1);
        check("rc4_blackout", 1, 32'(bus1.gnt_o), 32'h0);
      end
    end

    // Reseed of the count-4 instance with an explicit seed.
    seed = 32'hA5A5_0001; ack = 1'b1;
    cycle();
    check("ack_drop", 1, 32'(bus1.seed_req_o), 32'h0);
    ack = 1'b0;
    cycle();
    cycle();
    check("reseed_gnt", 1, 32'(bus1.gnt_o), 32'h1);
    check("reseed_data", 1, 32'(bus1.data_o), 32'h01);

    // Sole requester on bit 2; zero seed on reseed falls back to Seed.
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = 4'b0100; ack = 1'b1; seed = '0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("solo_gnt", 0, 32'(bus0.gnt_o), 32'h4);
      seen[i] = bus0.data_o;
      if (i == 6) check("zero_seed_data", 1, 32'(bus1.data_o), 32'h01);
    end
    rep = 0;
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++)
        if (seen[i] == seen[j]) rep++;
    check("solo_unique", 0, 32'(rep), 32'h0);
    check("zero_seed_lockup", 1, 32'(bus1.lockup_o), 32'h0);

    // Lockup: zero the LFSR state between edges.
    ack = 1'b0; req = 4'hF;
    cycle();
    cycle();
    @(negedge clk);
    force u_dut0.u_lfsr.lfsr_q = 32'h0;
    #1;
    release u_dut0.u_lfsr.lfsr_q;
    m_lfsr[0] = 32'h0;
    cycle();
    check("lockup_set", 0, 32'(bus0.lockup_o), 32'h1);
    check("lockup_nognt", 0, 32'(bus0.gnt_o), 32'h0);
    cycle();
    check("lockup_reload", 0, 32'(bus0.data_o), 32'h01);

    // Reset while waiting for a seed; a late ack is ignored.
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = '0; reseed = 1'b1;
    cycle();
    reseed = 1'b0;
    cycle();
    check("sreq_wait", 0, 32'(bus0.seed_req_o), 32'h1);
    rst = 1'b1;
    cycle();
    check("sreq_rst_req", 0, 32'(bus0.seed_req_o), 32'h0);
    check("sreq_rst_gnt", 0, 32'(bus0.gnt_o), 32'h0);
    rst = 1'b0; ack = 1'b1; seed = 32'h1234;
    cycle();
    check("late_ack", 0, 32'(bus0.seed_req_o), 32'h0);
    ack = 1'b0; req = 4'hF;
    cycle();
    check("post_rst_gnt", 0, 32'(bus0.gnt_o), 32'h1);
    check("post_rst_data", 0, 32'(bus0.data_o), 32'h01);

    // Randomized traffic, reseeds, acks and resets.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      req    = 4'($urandom_range(0, 15));
      reseed = ($urandom_range(0, 31) == 0);
      ack    = ($urandom_range(0, 2) == 0);
      seed   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
